// File: rtl/sr_hazard_ctrl_if.sv
// Decode/execute handshake between the sr_cpu pipeline and its sequencing controller.
// The master side drives the decoded instruction and the branch outcome; the slave side is the controller.
interface sr_hazard_ctrl_if;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i;
  logic [4:0]  id_rs2_i;
  logic        id_use_rs1_i;
  logic        id_use_rs2_i;
  logic [4:0]  id_rd_i;
  logic        id_regWrite_i;
  logic        id_branch_i;
  logic        ex_branch_taken_i;
  logic        issue_o;
  logic        stall_o;
  logic        flush_o;
  logic [1:0]  state_o;
  logic [15:0] stall_count_o;

  modport master (
    output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_regWrite_i, id_branch_i, ex_branch_taken_i,
    input  issue_o, stall_o, flush_o, state_o, stall_count_o
  );

  modport slave (
    input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
           id_rd_i, id_regWrite_i, id_branch_i, ex_branch_taken_i,
    output issue_o, stall_o, flush_o, state_o, stall_count_o
  );
endinterface

// File: rtl/sr_hazard_ctrl.sv
// Issue/stall/flush sequencing for the sr_cpu decode stage: RAW scoreboard,
// RUN/BR_WAIT/FLUSH branch handling and a saturating stall counter.
module sr_hazard_ctrl #(
  parameter int PIPE_DEPTH   = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sr_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    FLUSH   = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t      stateReg, stateNext;
  logic [2:0]  flushCntReg, flushCntNext;
  logic [15:0] stallCntReg;

  logic        sbValidReg [PIPE_DEPTH];
  logic [4:0]  sbRdReg    [PIPE_DEPTH];

  logic [PIPE_DEPTH-1:0] rs1Hit;
  logic [PIPE_DEPTH-1:0] rs2Hit;
  logic                  hazard;
  logic                  issueRaw, stallRaw, flushRaw;
  logic                  sbLoad;

  // Any in-flight writer of a read source blocks issue; x0 is never tracked.
  genvar gi;
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_match
      assign rs1Hit[gi] = sbValidReg[gi] && (sbRdReg[gi] == bus.id_rs1_i);
      assign rs2Hit[gi] = sbValidReg[gi] && (sbRdReg[gi] == bus.id_rs2_i);
    end
  endgenerate

  assign hazard = bus.id_valid_i &&
                  ((bus.id_use_rs1_i && (bus.id_rs1_i != 5'd0) && (|rs1Hit)) ||
                   (bus.id_use_rs2_i && (bus.id_rs2_i != 5'd0) && (|rs2Hit)));

  always_comb begin
    issueRaw     = 1'b0;
    stallRaw     = 1'b0;
    flushRaw     = 1'b0;
    stateNext    = stateReg;
    flushCntNext = flushCntReg;
    case (stateReg)
      RUN: begin
        issueRaw = bus.id_valid_i && !hazard;
        stallRaw = hazard;
        if (issueRaw && bus.id_branch_i) begin
          stateNext = BR_WAIT;
        end
      end
      BR_WAIT: begin
        stallRaw = 1'b1;
        if (bus.ex_branch_taken_i) begin
          stateNext    = FLUSH;
          flushCntNext = 3'(FLUSH_CYCLES - 1);
        end else begin
          stateNext = RUN;
        end
      end
      FLUSH: begin
        flushRaw = 1'b1;
        if (flushCntReg == 3'd0) begin
          stateNext = RUN;
        end else begin
          flushCntNext = flushCntReg - 3'd1;
        end
      end
      default: begin
        stateNext    = RUN;
        flushCntNext = 3'd0;
      end
    endcase
  end

  // Outputs are held low for the whole time reset is asserted, even with live id_* inputs.
  assign bus.issue_o       = issueRaw && rst_n;
  assign bus.stall_o       = stallRaw && rst_n;
  assign bus.flush_o       = flushRaw && rst_n;
  assign bus.state_o       = stateReg;
  assign bus.stall_count_o = stallCntReg;

  assign sbLoad = issueRaw && bus.id_regWrite_i && (bus.id_rd_i != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg    <= RUN;
      flushCntReg <= 3'd0;
      stallCntReg <= 16'd0;
    end else begin
      stateReg    <= stateNext;
      flushCntReg <= flushCntNext;
      if (stallRaw && (stallCntReg != 16'hFFFF)) begin
        stallCntReg <= stallCntReg + 16'd1;
      end
    end
  end

  // Scoreboard shifts every cycle regardless of state; the oldest entry falls off the end.
  generate
    for (gi = 0; gi < PIPE_DEPTH; gi++) begin : g_sb
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sbValidReg[gi] <= 1'b0;
          sbRdReg[gi]    <= 5'd0;
        end else if (gi == 0) begin
          sbValidReg[gi] <= sbLoad;
          sbRdReg[gi]    <= bus.id_rd_i;
        end else begin
          sbValidReg[gi] <= sbValidReg[(gi > 0) ? gi - 1 : 0];
          sbRdReg[gi]    <= sbRdReg[(gi > 0) ? gi - 1 : 0];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sr_hazard_ctrl.sv
// Directed checks of sr_hazard_ctrl with PIPE_DEPTH=2, FLUSH_CYCLES=2.
module tb_sr_hazard_ctrl;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sr_hazard_ctrl_if bus ();

  sr_hazard_ctrl #(
    .PIPE_DEPTH   (2),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic v, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic rw, input logic br);
    bus.id_valid_i    = v;
    bus.id_rs1_i      = rs1;
    bus.id_use_rs1_i  = u1;
    bus.id_rs2_i      = rs2;
    bus.id_use_rs2_i  = u2;
    bus.id_rd_i       = rd;
    bus.id_regWrite_i = rw;
    bus.id_branch_i   = br;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    bus.ex_branch_taken_i = 1'b0;
    present(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.ex_branch_taken_i = 1'b0;
    present(1, 0, 0, 0, 0, 0, 0, 0);
    #12;
    chk("rst_issue", bus.issue_o, 0);
    chk("rst_stall", bus.stall_o, 0);
    chk("rst_flush", bus.flush_o, 0);
    chk("rst_state", bus.state_o, 0);
    chk("rst_count", bus.stall_count_o, 0);

    // RAW on rs1: producer rd=5, dependent stalls 2 cycles then issues
    doReset();
    present(1, 0, 0, 0, 0, 5, 1, 0);
    chk("raw_prod_issue", bus.issue_o, 1);
    tick();
    present(1, 5, 1, 0, 0, 6, 1, 0);
    chk("raw_stall1", bus.stall_o, 1);
    chk("raw_stall1_iss", bus.issue_o, 0);
    tick();
    chk("raw_stall2", bus.stall_o, 1);
    chk("raw_cnt1", bus.stall_count_o, 1);
    tick();
    chk("raw_issue3", bus.issue_o, 1);
    chk("raw_nostall3", bus.stall_o, 0);
    chk("raw_cnt2", bus.stall_count_o, 2);
    $display("raw rs1 sequence: stall_count=%0d", bus.stall_count_o);

    // RAW on rs2
    doReset();
    present(1, 0, 0, 0, 0, 9, 1, 0);
    tick();
    present(1, 0, 0, 9, 1, 0, 0, 0);
    chk("raw_rs2_stall", bus.stall_o, 1);
    $display("raw rs2: stall=%0d", bus.stall_o);

    // x0 destination is never tracked
    doReset();
    present(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    present(1, 0, 1, 0, 0, 0, 0, 0);
    chk("x0_nostall", bus.stall_o, 0);
    chk("x0_issue", bus.issue_o, 1);
    $display("x0 reader: issue=%0d", bus.issue_o);

    // unused source does not hazard
    doReset();
    present(1, 0, 0, 0, 0, 7, 1, 0);
    tick();
    present(1, 0, 0, 7, 0, 0, 0, 0);
    chk("unused_nostall", bus.stall_o, 0);
    chk("unused_issue", bus.issue_o, 1);
    $display("unused rs2: issue=%0d", bus.issue_o);

    // hazarding branch stalls, stays in RUN, then issues
    doReset();
    present(1, 0, 0, 0, 0, 3, 1, 0);
    tick();
    present(1, 3, 1, 0, 0, 0, 0, 1);
    chk("hzbr_stall", bus.stall_o, 1);
    chk("hzbr_noissue", bus.issue_o, 0);
    tick();
    chk("hzbr_state_run", bus.state_o, 0);
    tick();
    chk("hzbr_issue", bus.issue_o, 1);
    tick();
    chk("hzbr_brwait", bus.state_o, 1);
    $display("hazard branch: state=%0d", bus.state_o);

    // taken branch: 1 stall + 2 flush cycles
    doReset();
    present(1, 0, 0, 0, 0, 0, 0, 1);
    chk("tk_issue", bus.issue_o, 1);
    tick();
    present(1, 0, 0, 0, 0, 0, 0, 0);
    chk("tk_state_bw", bus.state_o, 1);
    chk("tk_bw_stall", bus.stall_o, 1);
    chk("tk_bw_noissue", bus.issue_o, 0);
    bus.ex_branch_taken_i = 1'b1;
    #1;
    chk("tk_bw_noflush", bus.flush_o, 0);
    tick();
    bus.ex_branch_taken_i = 1'b0;
    #1;
    chk("tk_state_fl", bus.state_o, 2);
    chk("tk_flush1", bus.flush_o, 1);
    chk("tk_fl_noissue", bus.issue_o, 0);
    chk("tk_fl_nostall", bus.stall_o, 0);
    chk("tk_cnt", bus.stall_count_o, 1);
    tick();
    chk("tk_flush2", bus.flush_o, 1);
    tick();
    chk("tk_state_run", bus.state_o, 0);
    chk("tk_noflush", bus.flush_o, 0);
    chk("tk_issue_after", bus.issue_o, 1);
    $display("taken branch: back to RUN, issue=%0d", bus.issue_o);

    // not-taken branch: 1 stall cycle, no flush
    doReset();
    present(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    present(1, 0, 0, 0, 0, 0, 0, 0);
    chk("nt_state_bw", bus.state_o, 1);
    chk("nt_stall", bus.stall_o, 1);
    tick();
    chk("nt_state_run", bus.state_o, 0);
    chk("nt_noflush", bus.flush_o, 0);
    chk("nt_issue", bus.issue_o, 1);
    chk("nt_cnt", bus.stall_count_o, 1);
    $display("not-taken branch: stall_count=%0d", bus.stall_count_o);

    // reset during the first FLUSH cycle
    doReset();
    present(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
    present(1, 0, 0, 0, 0, 0, 0, 0);
    bus.ex_branch_taken_i = 1'b1;
    tick();
    bus.ex_branch_taken_i = 1'b0;
    chk("rf_in_flush", bus.flush_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rf_flush0", bus.flush_o, 0);
    chk("rf_issue0", bus.issue_o, 0);
    chk("rf_stall0", bus.stall_o, 0);
    chk("rf_state0", bus.state_o, 0);
    chk("rf_cnt0", bus.stall_count_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rf_issue_rel", bus.issue_o, 1);
    chk("rf_noflush_rel", bus.flush_o, 0);
    tick();
    chk("rf_noflush_edge", bus.flush_o, 0);
    chk("rf_state_edge", bus.state_o, 0);
    $display("reset mid-flush: state=%0d flush=%0d", bus.state_o, bus.flush_o);

    // saturation of the stall counter under a permanent hazard
    doReset();
    present(1, 0, 0, 0, 0, 0, 0, 0);
    force dut.hazard = 1'b1;
    #1;
    chk("sat_stall", bus.stall_o, 1);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", bus.stall_count_o, 32'h0000FFFE);
    tick();
    chk("sat_ffff", bus.stall_count_o, 32'h0000FFFF);
    repeat (4400) @(posedge clk);
    #1;
    chk("sat_hold", bus.stall_count_o, 32'h0000FFFF);
    release dut.hazard;
    $display("saturation: stall_count=%0h", bus.stall_count_o);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
